lsu_wb_pipelined: RTL and testbench

// - Parametrised load/store unit for the memory-access stage; successor to the single-request memory stage.
// - Accepts load/store ops from execute via valid/ready and issues them on a pipelined Wishbone master.
// - Keeps up to MAX_OUTST requests in flight and returns aligned, sign/zero-extended load data in order.
// - Traps misaligned or unsupported-width accesses without touching the bus.

---
 rtl/lsu_wb_pipelined.sv | 248 ++++++++++++++++++++++++
 tb/tb_lsu_wb_pipelined.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_wb_pipelined.sv
// Load/store unit: decodes execute ops, traps illegal ones, issues on pipelined Wishbone, returns extended load data in order.
// Latency: accept -> strobe 1 cycle; ack -> rsp 1 cycle (3 cycles accept-to-rsp with a zero-wait slave); reject -> fault 1 cycle.
// Backpressure: req_ready drops on a stalled strobe, MAX_OUTST in flight, flush, or pending flush discards.

module lsu_wb_fifo #(
    parameter int W = 8,
    parameter int D = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [W-1:0]           push_dat,
    input  logic                   pop,
    output logic [W-1:0]           pop_dat,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(D+1)-1:0] count
);
    // Small in-order FIFO for request tracking; single-cycle push/pop, no internal backpressure beyond full.
    // Latency: head valid the cycle after the first push.
    // Backpressure: push ignored when full unless popping in the same cycle.
    localparam int PTR_W = (D > 1) ? $clog2(D) : 1;
    localparam int CNT_W = $clog2(D + 1);

    logic [W-1:0]     mem [D];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(D - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CNT_W'(D));
    assign count   = cnt_q;
    assign pop_dat = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end
endmodule

module lsu_wb_pipelined #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MAX_OUTST = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_store,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [4:0]            req_rd,
    input  logic                  flush,
    output logic                  rsp_valid,
    output logic                  rsp_is_load,
    output logic [4:0]            rsp_rd,
    output logic [DATA_W-1:0]     rsp_data,
    output logic                  fault_valid,
    output logic                  fault_cause,
    output logic [ADDR_W-1:0]     fault_addr,
    output logic                  busy,
    output logic                  wb_cyc,
    output logic                  wb_stb,
    output logic                  wb_we,
    output logic [ADDR_W-1:0]     wb_addr,
    output logic [DATA_W-1:0]     wb_dat_o,
    output logic [DATA_W/8-1:0]   wb_sel,
    input  logic                  wb_ack,
    input  logic                  wb_stall,
    input  logic [DATA_W-1:0]     wb_dat_i
);
    localparam int SEL_W = DATA_W / 8;
    localparam int OFF_W = $clog2(SEL_W);
    localparam int TRK_W = 1 + 5 + 3 + OFF_W;
    localparam int CNT_W = $clog2(MAX_OUTST + 1);

    // Request decode
    logic [OFF_W-1:0] off;
    logic             misalign, unsupp, legal, accept;
    logic [SEL_W-1:0] width_mask;

    always_comb begin
        off        = req_addr[OFF_W-1:0];
        misalign   = 1'b0;
        width_mask = '0;
        case (req_funct3[1:0])
            2'b00: begin misalign = 1'b0;        width_mask = SEL_W'(8'h01); end
            2'b01: begin misalign = off[0];      width_mask = SEL_W'(8'h03); end
            2'b10: begin misalign = |off[1:0];   width_mask = SEL_W'(8'h0F); end
            default: begin misalign = |off;      width_mask = '1;            end
        endcase
        unsupp = (req_store && req_funct3[2]) || (req_funct3 == 3'b111) ||
                 ((DATA_W == 32) && ((req_funct3 == 3'b011) || (req_funct3 == 3'b110)));
        legal  = !misalign && !unsupp;
    end

    // Strobe stage and tracking state
    logic             stb_q, we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] dat_q;
    logic [SEL_W-1:0]  sel_q;
    logic [TRK_W-1:0]  trk_q;
    logic [CNT_W-1:0]  disc_q;

    logic             trk_push, trk_pop, trk_empty, trk_full;
    logic [TRK_W-1:0] trk_head;
    logic [CNT_W-1:0] trk_cnt, trk_cnt_next;
    logic [CNT_W:0]   cnt;

    assign trk_push     = stb_q && !wb_stall;
    assign trk_pop      = wb_ack && !trk_empty;
    assign trk_cnt_next = trk_cnt + CNT_W'(trk_push) - CNT_W'(trk_pop);
    assign cnt          = {1'b0, trk_cnt} + {{CNT_W{1'b0}}, stb_q};

    assign req_ready = !rst && !flush && (disc_q == '0) &&
                       (cnt < (CNT_W+1)'(MAX_OUTST)) && !(stb_q && wb_stall);
    assign accept    = req_valid && req_ready;

    lsu_wb_fifo #(.W(TRK_W), .D(MAX_OUTST)) u_trk (
        .clk      (clk),
        .rst      (rst),
        .push     (trk_push),
        .push_dat (trk_q),
        .pop      (trk_pop),
        .pop_dat  (trk_head),
        .empty    (trk_empty),
        .full     (trk_full),
        .count    (trk_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            stb_q  <= 1'b0;
            we_q   <= 1'b0;
            addr_q <= '0;
            dat_q  <= '0;
            sel_q  <= '0;
            trk_q  <= '0;
        end else if (accept && legal) begin
            stb_q  <= 1'b1;
            we_q   <= req_store;
            addr_q <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            dat_q  <= req_wdata << {off, 3'b000};
            sel_q  <= width_mask << off;
            trk_q  <= {!req_store, req_rd, req_funct3, off};
        end else if (flush || trk_push) begin
            stb_q  <= 1'b0;
        end
    end

    // A strobe the slave took during the flush cycle is already pushed, so count it in the discards.
    always_ff @(posedge clk) begin
        if (rst) begin
            disc_q <= '0;
        end else if (flush) begin
            disc_q <= trk_cnt_next;
        end else if (trk_pop && (disc_q != '0)) begin
            disc_q <= disc_q - 1'b1;
        end
    end

    // Response extraction from the head of the tracking FIFO
    logic             h_load;
    logic [4:0]       h_rd;
    logic [2:0]       h_f3;
    logic [OFF_W-1:0] h_off;
    logic [DATA_W-1:0] sh, ld_ext;

    assign {h_load, h_rd, h_f3, h_off} = trk_head;

    always_comb begin
        sh     = wb_dat_i >> {h_off, 3'b000};
        ld_ext = sh;
        case (h_f3)
            3'b000:  ld_ext = DATA_W'($signed(sh[7:0]));
            3'b001:  ld_ext = DATA_W'($signed(sh[15:0]));
            3'b010:  ld_ext = DATA_W'($signed(sh[31:0]));
            3'b100:  ld_ext = DATA_W'(sh[7:0]);
            3'b101:  ld_ext = DATA_W'(sh[15:0]);
            3'b110:  ld_ext = DATA_W'(sh[31:0]);
            default: ld_ext = sh;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid   <= 1'b0;
            rsp_is_load <= 1'b0;
            rsp_rd      <= '0;
            rsp_data    <= '0;
            fault_valid <= 1'b0;
            fault_cause <= 1'b0;
            fault_addr  <= '0;
        end else begin
            rsp_valid   <= 1'b0;
            rsp_is_load <= 1'b0;
            rsp_rd      <= '0;
            rsp_data    <= '0;
            fault_valid <= 1'b0;
            fault_cause <= 1'b0;
            fault_addr  <= '0;
            if (trk_pop && (disc_q == '0) && !flush) begin
                rsp_valid   <= 1'b1;
                rsp_is_load <= h_load;
                rsp_rd      <= h_load ? h_rd : 5'd0;
                rsp_data    <= h_load ? ld_ext : '0;
            end
            if (accept && !legal) begin
                fault_valid <= 1'b1;
                fault_cause <= !misalign;
                fault_addr  <= req_addr;
            end
        end
    end

    assign wb_stb   = stb_q;
    assign wb_we    = we_q;
    assign wb_addr  = addr_q;
    assign wb_dat_o = dat_q;
    assign wb_sel   = sel_q;
    assign wb_cyc   = stb_q || !trk_empty;
    assign busy     = stb_q || !trk_empty;
endmodule

// File: tb/tb_lsu_wb_pipelined.sv
// Directed bench for lsu_wb_pipelined at DATA_W=32, ADDR_W=32, MAX_OUTST=2; the bench plays the Wishbone slave by hand.
module tb_lsu_wb_pipelined;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_ready, req_store = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [4:0]  req_rd = '0;
    logic        flush = 1'b0;
    logic        rsp_valid, rsp_is_load;
    logic [4:0]  rsp_rd;
    logic [31:0] rsp_data;
    logic        fault_valid, fault_cause;
    logic [31:0] fault_addr;
    logic        busy, wb_cyc, wb_stb, wb_we;
    logic [31:0] wb_addr, wb_dat_o;
    logic [3:0]  wb_sel;
    logic        wb_ack = 1'b0, wb_stall = 1'b0;
    logic [31:0] wb_dat_i = '0;

    int vecs = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    lsu_wb_pipelined #(.DATA_W(32), .ADDR_W(32), .MAX_OUTST(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .flush(flush),
        .rsp_valid(rsp_valid), .rsp_is_load(rsp_is_load), .rsp_rd(rsp_rd), .rsp_data(rsp_data),
        .fault_valid(fault_valid), .fault_cause(fault_cause), .fault_addr(fault_addr),
        .busy(busy), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_addr(wb_addr),
        .wb_dat_o(wb_dat_o), .wb_sel(wb_sel), .wb_ack(wb_ack), .wb_stall(wb_stall), .wb_dat_i(wb_dat_i)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vecs++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [4:0] rd);
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        req_rd     = rd;
    endtask

    // One op through a zero-wait slave that acks the cycle after the strobe.
    task automatic single(input string tag, input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [4:0] rd, input logic [31:0] rdata,
                          input logic [3:0] exp_sel, input logic [31:0] exp_dat_o, input logic [31:0] exp_rsp);
        set_req(st, f3, a, wd, rd);
        #1;
        check({tag, ".ready"}, req_ready, 1);
        step();
        req_valid = 1'b0;
        check({tag, ".stb"}, wb_stb, 1);
        check({tag, ".we"}, wb_we, st);
        check({tag, ".addr"}, wb_addr, a & 32'hFFFF_FFFC);
        check({tag, ".sel"}, wb_sel, exp_sel);
        if (st) check({tag, ".dat_o"}, wb_dat_o, exp_dat_o);
        step();
        check({tag, ".stb_drop"}, wb_stb, 0);
        check({tag, ".cyc_hold"}, wb_cyc, 1);
        wb_ack = 1'b1;
        wb_dat_i = rdata;
        step();
        wb_ack = 1'b0;
        wb_dat_i = '0;
        check({tag, ".rsp_valid"}, rsp_valid, 1);
        check({tag, ".rsp_data"}, rsp_data, exp_rsp);
        check({tag, ".rsp_is_load"}, rsp_is_load, !st);
        check({tag, ".rsp_rd"}, rsp_rd, st ? 5'd0 : rd);
        check({tag, ".cyc_drop"}, wb_cyc, 0);
        step();
        check({tag, ".rsp_pulse"}, rsp_valid, 0);
    endtask

    task automatic reject(input string tag, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic exp_cause);
        set_req(st, f3, a, 32'h0, 5'd7);
        step();
        req_valid = 1'b0;
        check({tag, ".no_stb"}, wb_stb, 0);
        check({tag, ".fault_valid"}, fault_valid, 1);
        check({tag, ".fault_cause"}, fault_cause, exp_cause);
        check({tag, ".fault_addr"}, fault_addr, a);
        step();
        check({tag, ".fault_pulse"}, fault_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        step(); step(); step();
        check("rst.ready", req_ready, 0);
        check("rst.cyc", wb_cyc, 0);
        check("rst.stb", wb_stb, 0);
        check("rst.busy", busy, 0);
        check("rst.rsp_valid", rsp_valid, 0);
        check("rst.fault_valid", fault_valid, 0);
        rst = 1'b0;
        #1;
        check("idle.ready", req_ready, 1);

        single("lw",  1'b0, 3'b010, 32'h100, 32'h0,    5'd5, 32'h8000_00F0, 4'b1111, 32'h0,         32'h8000_00F0);
        single("lb",  1'b0, 3'b000, 32'h103, 32'h0,    5'd6, 32'h8A00_0000, 4'b1000, 32'h0,         32'hFFFF_FF8A);
        single("lbu", 1'b0, 3'b100, 32'h103, 32'h0,    5'd6, 32'h8A00_0000, 4'b1000, 32'h0,         32'h0000_008A);
        single("sh",  1'b1, 3'b001, 32'h102, 32'h1234, 5'd0, 32'hFFFF_FFFF, 4'b1100, 32'h1234_0000, 32'h0);
        single("lh",  1'b0, 3'b001, 32'h102, 32'h0,    5'd9, 32'h8001_0000, 4'b1100, 32'h0,         32'hFFFF_8001);
        single("lhu", 1'b0, 3'b101, 32'h102, 32'h0,    5'd9, 32'h8001_0000, 4'b1100, 32'h0,         32'h0000_8001);
        single("sb",  1'b1, 3'b000, 32'h101, 32'hA5,   5'd0, 32'h0,         4'b0010, 32'h0000_A500, 32'h0);

        reject("lh_mis",   1'b0, 3'b001, 32'h101, 1'b0);
        reject("lw_mis",   1'b0, 3'b010, 32'h102, 1'b0);
        reject("ld32",     1'b0, 3'b011, 32'h100, 1'b1);
        reject("lwu32",    1'b0, 3'b110, 32'h100, 1'b1);
        reject("st_f4",    1'b1, 3'b100, 32'h100, 1'b1);
        reject("f7_mis",   1'b0, 3'b111, 32'h101, 1'b0);

        // Back-to-back loads with the first strobe stalled for three cycles.
        wb_stall = 1'b1;
        set_req(1'b0, 3'b010, 32'h200, 32'h0, 5'd1);
        step();
        set_req(1'b0, 3'b010, 32'h204, 32'h0, 5'd2);
        for (int i = 0; i < 3; i++) begin
            check("stall.stb", wb_stb, 1);
            check("stall.addr", wb_addr, 32'h200);
            check("stall.ready", req_ready, 0);
            step();
        end
        wb_stall = 1'b0;
        #1;
        check("stall.release_ready", req_ready, 1);
        step();
        req_valid = 1'b0;
        check("b2b.stb2", wb_stb, 1);
        check("b2b.addr2", wb_addr, 32'h204);
        check("b2b.ready_full", req_ready, 0);
        step();
        check("b2b.stb_drop", wb_stb, 0);
        check("b2b.ready_full2", req_ready, 0);
        wb_ack = 1'b1;
        wb_dat_i = 32'h1111_1111;
        step();
        check("b2b.rsp1_valid", rsp_valid, 1);
        check("b2b.rsp1_rd", rsp_rd, 1);
        check("b2b.rsp1_data", rsp_data, 32'h1111_1111);
        wb_dat_i = 32'h2222_2222;
        step();
        wb_ack = 1'b0;
        check("b2b.rsp2_valid", rsp_valid, 1);
        check("b2b.rsp2_rd", rsp_rd, 2);
        check("b2b.rsp2_data", rsp_data, 32'h2222_2222);
        check("b2b.cyc_drop", wb_cyc, 0);

        // Two loads in flight, then flush: both acks discarded.
        set_req(1'b0, 3'b010, 32'h300, 32'h0, 5'd3);
        step();
        set_req(1'b0, 3'b010, 32'h304, 32'h0, 5'd4);
        step();
        req_valid = 1'b0;
        step();
        check("flush.pre_cyc", wb_cyc, 1);
        flush = 1'b1;
        set_req(1'b0, 3'b010, 32'h308, 32'h0, 5'd8);
        #1;
        check("flush.ready", req_ready, 0);
        step();
        flush = 1'b0;
        req_valid = 1'b0;
        check("flush.no_stb", wb_stb, 0);
        check("flush.disc_ready", req_ready, 0);
        wb_ack = 1'b1;
        wb_dat_i = 32'hDEAD_BEEF;
        step();
        check("flush.ack1_rsp", rsp_valid, 0);
        check("flush.ack1_ready", req_ready, 0);
        step();
        wb_ack = 1'b0;
        #1;
        check("flush.ack2_rsp", rsp_valid, 0);
        check("flush.ready_back", req_ready, 1);
        check("flush.cyc_drop", wb_cyc, 0);

        // Flush withdraws a stalled strobe before it is ever pushed.
        wb_stall = 1'b1;
        set_req(1'b0, 3'b010, 32'h400, 32'h0, 5'd10);
        step();
        req_valid = 1'b0;
        check("wd.stb", wb_stb, 1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        wb_stall = 1'b0;
        #1;
        check("wd.stb_gone", wb_stb, 0);
        check("wd.cyc", wb_cyc, 0);
        check("wd.ready", req_ready, 1);

        // Reset with two loads outstanding; later acks are strays.
        set_req(1'b0, 3'b010, 32'h500, 32'h0, 5'd11);
        step();
        set_req(1'b0, 3'b010, 32'h504, 32'h0, 5'd12);
        step();
        req_valid = 1'b0;
        step();
        check("rst2.busy_pre", busy, 1);
        rst = 1'b1;
        step();
        check("rst2.cyc", wb_cyc, 0);
        check("rst2.stb", wb_stb, 0);
        check("rst2.busy", busy, 0);
        check("rst2.ready", req_ready, 0);
        check("rst2.sel", wb_sel, 0);
        check("rst2.addr", wb_addr, 0);
        rst = 1'b0;
        wb_ack = 1'b1;
        wb_dat_i = 32'h5555_5555;
        step();
        check("rst2.ack1_rsp", rsp_valid, 0);
        step();
        wb_ack = 1'b0;
        check("rst2.ack2_rsp", rsp_valid, 0);
        check("rst2.ready_after", req_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end
endmodule
